// File: rtl/xor_descrambler_if.sv
`default_nettype none
// ------------------------------------------------------------------
// xor_descrambler_if : seed control + byte stream bundle
// Rev 1.0
// ------------------------------------------------------------------
interface xor_descrambler_if;
  logic        seed_load;
  logic [7:0]  seed;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [15:0] byte_cnt;
  logic        busy;

  modport master (
    output seed_load, seed, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, byte_cnt, busy
  );

  modport slave (
    input  seed_load, seed, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, byte_cnt, busy
  );
endinterface
`default_nettype wire

// File: rtl/xor_descrambler.sv
`default_nettype none
// ------------------------------------------------------------------
// xor_descrambler : XORs each byte with an 8-bit Fibonacci LFSR keystream
// Rev 1.0
// ------------------------------------------------------------------
module xor_descrambler #(
  parameter logic [7:0] ZERO_SUB = 8'h01
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  xor_descrambler_if.slave dsc
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  lfsr_q, lfsr_d;
  logic        out_valid_q, out_valid_d;
  logic [7:0]  out_data_q, out_data_d;
  logic [15:0] byte_cnt_q, byte_cnt_d;

  logic        in_ready;
  logic        in_hs;
  logic        out_hs;
  logic [7:0]  lfsr_load;
  logic [7:0]  lfsr_step;

  // An all-zero seed would lock the LFSR at zero, so it is substituted.
  assign lfsr_load = (dsc.seed == 8'h00) ? ZERO_SUB : dsc.seed;
  assign lfsr_step = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  assign in_ready = (state_q == S_RUN) && !dsc.seed_load && (!out_valid_q || dsc.out_ready);
  assign in_hs    = dsc.in_valid && in_ready;
  assign out_hs   = out_valid_q && dsc.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      lfsr_q      <= 8'h00;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      byte_cnt_q  <= 16'h0000;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      byte_cnt_q  <= byte_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    byte_cnt_d  = byte_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (dsc.seed_load) begin
          state_d = S_RUN;
          lfsr_d  = lfsr_load;
        end
      end
      S_RUN: begin
        if (dsc.seed_load) begin
          lfsr_d = lfsr_load;
        end else if (in_hs) begin
          lfsr_d = lfsr_step;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A pending byte survives seed_load; it leaves only through its handshake.
    if (out_hs) begin
      out_valid_d = 1'b0;
      byte_cnt_d  = byte_cnt_q + 16'h0001;
    end
    if (in_hs) begin
      out_valid_d = 1'b1;
      out_data_d  = dsc.in_data ^ lfsr_q;
    end
  end

  assign dsc.in_ready  = in_ready;
  assign dsc.out_valid = out_valid_q;
  assign dsc.out_data  = out_data_q;
  assign dsc.byte_cnt  = byte_cnt_q;
  assign dsc.busy      = (state_q == S_RUN);

endmodule
`default_nettype wire

// File: tb/tb_xor_descrambler.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_xor_descrambler : directed + randomized checks against a byte-queue model
// Rev 1.0
// ------------------------------------------------------------------
module tb_xor_descrambler;
  localparam logic [7:0] ZSUB = 8'h01;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  xor_descrambler_if bus ();

  xor_descrambler #(.ZERO_SUB(ZSUB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .dsc   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference: keystream position plus a queue of bytes awaiting delivery
  bit         m_run;
  logic [7:0] m_key;
  logic [7:0] m_pend[$];
  logic [15:0] m_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] next_key(input logic [7:0] k);
    int fb;
    fb = ((k >> 7) + (k >> 5) + (k >> 4) + (k >> 3)) % 2;
    return 8'((k * 2 + fb) % 256);
  endfunction

  task automatic model_reset();
    m_run = 1'b0;
    m_key = 8'h00;
    m_pend.delete();
    m_cnt = 16'h0000;
  endtask

  task automatic drv(input bit sl, input logic [7:0] sd, input bit iv,
                     input logic [7:0] id, input bit ordy);
    bus.seed_load = sl;
    bus.seed      = sd;
    bus.in_valid  = iv;
    bus.in_data   = id;
    bus.out_ready = ordy;
  endtask

  // Called just after a rising edge; checks in_ready, takes one edge, checks registers.
  task automatic tick(input string tag);
    bit exp_rdy, ohs, ihs;
    #1;
    exp_rdy = m_run && !bus.seed_load && (m_pend.size() == 0 || bus.out_ready);
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'(exp_rdy));
    @(posedge clk);
    ohs = (m_pend.size() != 0) && bus.out_ready;
    ihs = bus.in_valid && exp_rdy;
    if (ohs) begin
      void'(m_pend.pop_front());
      m_cnt = m_cnt + 16'h0001;
    end
    if (ihs) begin
      m_pend.push_back(bus.in_data ^ m_key);
      m_key = next_key(m_key);
    end
    if (bus.seed_load) begin
      m_key = (bus.seed == 8'h00) ? ZSUB : bus.seed;
      m_run = 1'b1;
    end
    #1;
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(m_pend.size() != 0));
    chk({tag, ".byte_cnt"},  32'(bus.byte_cnt),  32'(m_cnt));
    chk({tag, ".busy"},      32'(bus.busy),      32'(m_run));
    if (m_pend.size() != 0)
      chk({tag, ".out_data"}, 32'(bus.out_data), 32'(m_pend[0]));
  endtask

  task automatic async_reset(input string tag);
    #1 rst_n = 1'b0;
    #1;
    chk({tag, ".rst_out_valid"}, 32'(bus.out_valid), 32'h0);
    chk({tag, ".rst_out_data"},  32'(bus.out_data),  32'h0);
    chk({tag, ".rst_byte_cnt"},  32'(bus.byte_cnt),  32'h0);
    chk({tag, ".rst_in_ready"},  32'(bus.in_ready),  32'h0);
    chk({tag, ".rst_busy"},      32'(bus.busy),      32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
  endtask

  initial begin
    drv(0, 8'h00, 0, 8'h00, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("por.out_valid", 32'(bus.out_valid), 32'h0);
    chk("por.out_data",  32'(bus.out_data),  32'h0);
    chk("por.byte_cnt",  32'(bus.byte_cnt),  32'h0);
    chk("por.in_ready",  32'(bus.in_ready),  32'h0);
    chk("por.busy",      32'(bus.busy),      32'h0);
    rst_n = 1'b1;
    @(posedge clk);

    // Data offered in IDLE is ignored
    drv(0, 8'h00, 1, 8'h33, 1);
    repeat (3) tick("idle");
    chk("idle.cnt", 32'(bus.byte_cnt), 32'h0);

    // Basic seed A5 stream
    drv(1, 8'hA5, 0, 8'h00, 1); tick("a5.load");
    drv(0, 8'h00, 1, 8'hF0, 1); tick("a5.b0");
    chk("a5.b0.const", 32'(bus.out_data), 32'h55);
    tick("a5.b1");
    chk("a5.b1.const", 32'(bus.out_data), 32'hBA);
    drv(0, 8'h00, 0, 8'h00, 1); tick("a5.drain");
    chk("a5.cnt.const", 32'(bus.byte_cnt), 32'h2);

    // Zero seed uses the substitute value
    drv(1, 8'h00, 0, 8'h00, 1); tick("z.load");
    drv(0, 8'h00, 1, 8'h00, 1); tick("z.b0");
    chk("z.b0.const", 32'(bus.out_data), 32'h01);
    drv(0, 8'h00, 0, 8'h00, 1); tick("z.drain");

    // Backpressure holds output and keystream
    drv(1, 8'hA5, 0, 8'h00, 0); tick("bp.load");
    drv(0, 8'h00, 1, 8'hF0, 0); tick("bp.b0");
    repeat (5) tick("bp.hold");
    chk("bp.hold.const", 32'(bus.out_data), 32'h55);
    drv(0, 8'h00, 1, 8'hF0, 1); tick("bp.b1");
    chk("bp.b1.const", 32'(bus.out_data), 32'hBA);
    drv(0, 8'h00, 0, 8'h00, 1); tick("bp.drain");

    // Reset mid-stream drops the pending byte
    drv(1, 8'hA5, 0, 8'h00, 0); tick("mr.load");
    drv(0, 8'h00, 1, 8'hF0, 0); tick("mr.b0");
    drv(0, 8'h00, 0, 8'h00, 0);
    async_reset("mr");
    drv(0, 8'h00, 1, 8'hF0, 1); tick("mr.idle");
    drv(1, 8'hA5, 0, 8'h00, 1); tick("mr.reload");
    drv(0, 8'h00, 1, 8'hF0, 1); tick("mr.b1");
    chk("mr.b1.const", 32'(bus.out_data), 32'h55);
    drv(0, 8'h00, 0, 8'h00, 1); tick("mr.drain");

    // seed_load beats in_valid in the same cycle
    drv(1, 8'hA5, 1, 8'hF0, 1); tick("sl.col");
    drv(0, 8'h00, 1, 8'hF0, 1); tick("sl.b0");
    chk("sl.b0.const", 32'(bus.out_data), 32'h55);
    drv(0, 8'h00, 0, 8'h00, 1); tick("sl.drain");

    // Randomized traffic, occasional reloads and one mid-run reset
    for (int i = 0; i < 600; i++) begin
      logic [7:0] sd;
      sd = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      drv($urandom_range(0, 15) == 0, sd, $urandom_range(0, 3) != 0,
          8'($urandom), $urandom_range(0, 3) != 0);
      if (i == 300) async_reset("rnd");
      else tick("rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
